// File: rtl/spi_ram_pkg.sv
// Shared command encoding for the SPI slave and the RAM controller.
package spi_ram_pkg;

  localparam int CMD_W     = 2;
  localparam int PAYLOAD_W = 8;

  localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

  typedef struct packed {
    logic [CMD_W-1:0]     cmd;
    logic [PAYLOAD_W-1:0] payload;
  } rx_word_t;

endpackage

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind the SPI slave.
// Define SPI_RAM_AUTOINC_EN to post-increment the addresses after each data access.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CMD_W+PAYLOAD_W-1:0]     din,
  input  logic                           rx_valid,
  output logic [PAYLOAD_W-1:0]           dout,
  output logic                           tx_valid,
  output logic                           cmd_err
);

  localparam logic [ADDR_SIZE:0]   ADDR_LIMIT = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR  = ADDR_SIZE'(MEM_DEPTH - 1);

  logic [PAYLOAD_W-1:0] mem [MEM_DEPTH];

  logic                 rx_valid_q;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_armed_q, wr_armed_d;
  logic                 rd_armed_q, rd_armed_d;
  logic [PAYLOAD_W-1:0] dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 cmd_err_q, cmd_err_d;

  rx_word_t             word_s;
  logic                 accept_s;
  logic [ADDR_SIZE-1:0] addr_s;
  logic                 addr_ok_s;
  logic                 mem_we_s;

  assign word_s    = rx_word_t'(din);
  assign accept_s  = rx_valid & ~rx_valid_q;
  assign addr_s    = word_s.payload[ADDR_SIZE-1:0];
  assign addr_ok_s = ({1'b0, addr_s} < ADDR_LIMIT);

`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_SIZE'(1'b1);
  endfunction
`endif

  // Decode one accepted command into next-state register values.
  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_armed_d = wr_armed_q;
    rd_armed_d = rd_armed_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    mem_we_s   = 1'b0;
    if (accept_s) begin
      case (word_s.cmd)
        CMD_WR_ADDR: begin
          wr_addr_d  = addr_s;
          wr_armed_d = addr_ok_s;
          cmd_err_d  = ~addr_ok_s;
        end
        CMD_WR_DATA: begin
          if (wr_armed_q) begin
            mem_we_s = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            wr_addr_d = next_addr(wr_addr_q);
`else
            wr_addr_d = wr_addr_q;
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_addr_d  = addr_s;
          rd_armed_d = addr_ok_s;
          cmd_err_d  = ~addr_ok_s;
        end
        CMD_RD_DATA: begin
          // Payload is a dummy byte; an armed address is always in range.
          if (rd_armed_q) begin
            dout_d     = mem[rd_addr_q];
            tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr_d = next_addr(rd_addr_q);
`else
            rd_addr_d = rd_addr_q;
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: begin
          cmd_err_d = 1'b0;
        end
      endcase
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_armed_q <= 1'b0;
      rd_armed_q <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_armed_q <= wr_armed_d;
      rd_armed_q <= rd_armed_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Memory array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem[wr_addr_q] <= word_s.payload;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomized self-checking bench for spi_ram_ctrl against a behavioural memory model.
module tb_spi_ram_ctrl;

  localparam int DEPTH = 200;
  localparam int ASZ   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = 10'd0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  int errors = 0;
  int checks = 0;

  spi_ram_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(ASZ)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] mem_m [256];
  bit         known_m [256];
  int         wr_addr_m, rd_addr_m;
  bit         wr_armed_m, rd_armed_m;
  logic [7:0] dout_m;
  bit         dout_known_m;

  // Results of the most recent command
  bit         etx, eerr, eknown;
  logic [7:0] edout;
  int         tx_c, err_c;
  logic [7:0] d_o;

  function automatic void model_reset();
    wr_addr_m = 0; rd_addr_m = 0;
    wr_armed_m = 0; rd_armed_m = 0;
    dout_m = 8'h00; dout_known_m = 1;
  endfunction

  function automatic void model_cmd(input logic [1:0] cmd, input logic [7:0] pl);
    int a;
    a = int'(pl) % (1 << ASZ);
    etx = 0; eerr = 0;
    case (cmd)
      2'd0: begin wr_addr_m = a; wr_armed_m = (a < DEPTH); eerr = !(a < DEPTH); end
      2'd2: begin rd_addr_m = a; rd_armed_m = (a < DEPTH); eerr = !(a < DEPTH); end
      2'd1: begin
        if (wr_armed_m) begin
          mem_m[wr_addr_m] = pl; known_m[wr_addr_m] = 1;
`ifdef SPI_RAM_AUTOINC_EN
          wr_addr_m = (wr_addr_m + 1) % DEPTH;
`endif
        end else eerr = 1;
      end
      default: begin
        if (rd_armed_m) begin
          etx = 1; dout_m = mem_m[rd_addr_m]; dout_known_m = known_m[rd_addr_m];
`ifdef SPI_RAM_AUTOINC_EN
          rd_addr_m = (rd_addr_m + 1) % DEPTH;
`endif
        end else eerr = 1;
      end
    endcase
    edout = dout_m; eknown = dout_known_m;
  endfunction

  // Present one command for 'hold' cycles, then drop rx_valid for one cycle; count pulses.
  task automatic run(input logic [1:0] cmd, input logic [7:0] pl, input int hold);
    model_cmd(cmd, pl);
    tx_c = 0; err_c = 0;
    @(negedge clk); din = {cmd, pl}; rx_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == 0) d_o = dout;
      tx_c += int'(tx_valid); err_c += int'(cmd_err);
    end
    @(negedge clk); rx_valid = 1'b0;
    @(posedge clk); #1;
    tx_c += int'(tx_valid); err_c += int'(cmd_err);
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1; rx_valid = 1'b0; din = 10'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
  endtask

  task automatic test_write_read();
    int errs;
    apply_reset();
    run(2'b00, 8'h05, 1); errs = err_c;
    run(2'b01, 8'hA5, 1); errs += err_c;
    run(2'b10, 8'h05, 1); errs += err_c;
    run(2'b11, 8'h00, 1); errs += err_c;
    checks++; if (tx_c !== 1) begin errors++; $display("FAIL wr_rd_tx_pulses got=%0d exp=1", tx_c); end
    checks++; if (d_o !== 8'hA5) begin errors++; $display("FAIL wr_rd_dout got=%h exp=a5", d_o); end
    checks++; if (errs !== 0) begin errors++; $display("FAIL wr_rd_cmd_err got=%0d exp=0", errs); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL wr_rd_dout_hold got=%h exp=a5", dout); end
  endtask

  task automatic test_out_of_order();
    apply_reset();
    run(2'b00, 8'h00, 1); run(2'b01, 8'h3C, 1);
    apply_reset();
    run(2'b01, 8'hFF, 1);
    checks++; if (err_c !== 1) begin errors++; $display("FAIL ooo_wr_data_err got=%0d exp=1", err_c); end
    run(2'b11, 8'h00, 1);
    checks++; if (err_c !== 1 || tx_c !== 0) begin errors++; $display("FAIL ooo_rd_data got err=%0d tx=%0d exp err=1 tx=0", err_c, tx_c); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL ooo_dout got=%h exp=00", dout); end
    run(2'b10, 8'h00, 1); run(2'b11, 8'h00, 1);
    checks++; if (d_o !== 8'h3C) begin errors++; $display("FAIL ooo_no_write got=%h exp=3c", d_o); end
  endtask

  task automatic test_level_hold();
    apply_reset();
    run(2'b10, 8'h05, 1);
    run(2'b11, 8'h00, 12);
    checks++; if (tx_c !== 1 || err_c !== 0) begin errors++; $display("FAIL hold_pulses got tx=%0d err=%0d exp tx=1 err=0", tx_c, err_c); end
    checks++; if (d_o !== 8'hA5) begin errors++; $display("FAIL hold_dout got=%h exp=a5", d_o); end
  endtask

  task automatic test_range();
    apply_reset();
    run(2'b00, 8'hC8, 1);
    checks++; if (err_c !== 1) begin errors++; $display("FAIL range_wr_addr_err got=%0d exp=1", err_c); end
    run(2'b01, 8'h11, 1);
    checks++; if (err_c !== 1) begin errors++; $display("FAIL range_wr_data_err got=%0d exp=1", err_c); end
    run(2'b10, 8'hC8, 1);
    checks++; if (err_c !== 1) begin errors++; $display("FAIL range_rd_addr_err got=%0d exp=1", err_c); end
    run(2'b11, 8'h00, 1);
    checks++; if (err_c !== 1 || tx_c !== 0) begin errors++; $display("FAIL range_rd_data got err=%0d tx=%0d exp err=1 tx=0", err_c, tx_c); end
    run(2'b00, 8'hC7, 1);
    checks++; if (err_c !== 0) begin errors++; $display("FAIL range_last_ok got=%0d exp=0", err_c); end
    run(2'b10, 8'h00, 1); run(2'b11, 8'h00, 1);
    checks++; if (d_o !== 8'h3C) begin errors++; $display("FAIL range_mem_unchanged got=%h exp=3c", d_o); end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    run(2'b10, 8'h05, 1);
    @(negedge clk); din = 10'h300; rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (tx_valid !== 1'b0 || dout !== 8'h00 || cmd_err !== 1'b0) begin
      errors++; $display("FAIL mid_read_reset got tx=%b dout=%h err=%b exp tx=0 dout=00 err=0", tx_valid, dout, cmd_err);
    end
    @(negedge clk); rst = 1'b0; model_reset();
    run(2'b11, 8'h00, 1);
    checks++; if (err_c !== 1 || tx_c !== 0) begin errors++; $display("FAIL mid_read_rearm got err=%0d tx=%0d exp err=1 tx=0", err_c, tx_c); end
  endtask

  task automatic test_first_edge();
    @(negedge clk); rst = 1'b1; din = 10'h300; rx_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL first_edge_in_reset got=%b exp=0", cmd_err); end
    @(negedge clk); rst = 1'b0; model_reset();
    @(posedge clk); #1;
    checks++; if (cmd_err !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL first_edge_accept got err=%b tx=%b exp err=1 tx=0", cmd_err, tx_valid); end
    @(negedge clk); rx_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL first_edge_one_cycle got=%b exp=0", cmd_err); end
  endtask

`ifdef SPI_RAM_AUTOINC_EN
  task automatic test_autoinc();
    apply_reset();
    run(2'b00, 8'(DEPTH - 1), 1); run(2'b01, 8'h11, 1); run(2'b01, 8'h22, 1);
    run(2'b10, 8'(DEPTH - 1), 1);
    run(2'b11, 8'h00, 1);
    checks++; if (d_o !== 8'h11) begin errors++; $display("FAIL autoinc_rd0 got=%h exp=11", d_o); end
    run(2'b11, 8'h00, 1);
    checks++; if (d_o !== 8'h22 || err_c !== 0) begin errors++; $display("FAIL autoinc_wrap got=%h err=%0d exp=22 err=0", d_o, err_c); end
  endtask
`else
  task automatic test_no_autoinc();
    apply_reset();
    run(2'b00, 8'h0A, 1); run(2'b01, 8'h01, 1); run(2'b01, 8'h02, 1);
    run(2'b10, 8'h0A, 1);
    run(2'b11, 8'h00, 1);
    checks++; if (d_o !== 8'h02) begin errors++; $display("FAIL fixed_addr_rd0 got=%h exp=02", d_o); end
    run(2'b11, 8'h00, 1);
    checks++; if (d_o !== 8'h02 || tx_c !== 1) begin errors++; $display("FAIL fixed_addr_rd1 got=%h tx=%0d exp=02 tx=1", d_o, tx_c); end
  endtask
`endif

  task automatic test_random();
    logic [1:0] cmd;
    logic [7:0] pl;
    for (int n = 0; n < 150; n++) begin
      cmd = 2'($urandom_range(0, 3));
      pl  = 8'($urandom_range(0, 255));
      if (cmd[0] == 1'b0 && $urandom_range(0, 9) < 8) pl = 8'($urandom_range(0, DEPTH - 1));
      run(cmd, pl, $urandom_range(1, 3));
      checks++; if (err_c !== int'(eerr) || tx_c !== int'(etx)) begin
        errors++; $display("FAIL rand_%0d_strobes cmd=%0d pl=%h got err=%0d tx=%0d exp err=%0d tx=%0d", n, cmd, pl, err_c, tx_c, eerr, etx);
      end
      if (etx && eknown) begin
        checks++; if (d_o !== edout) begin errors++; $display("FAIL rand_%0d_dout got=%h exp=%h", n, d_o, edout); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) known_m[i] = 0;
    model_reset();
    test_reset();
    test_write_read();
    test_out_of_order();
    test_level_hold();
    test_range();
    test_reset_mid_read();
    test_first_edge();
`ifdef SPI_RAM_AUTOINC_EN
    test_autoinc();
`else
    test_no_autoinc();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
